// File: rtl/spy_pkg.sv
// Shared definitions for the spy recorder: FSM state encoding and freeze-mode codes.
package spy_pkg;

  typedef enum logic [1:0] {
    ST_RECORD = 2'd0,
    ST_ARMED  = 2'd1,
    ST_FROZEN = 2'd2
  } state_t;

  localparam logic [1:0] MODE_IMMEDIATE  = 2'd0;
  localparam logic [1:0] MODE_POST_COUNT = 2'd1;
  localparam logic [1:0] MODE_EVENT_END  = 2'd2;

  // The reserved code 3 behaves exactly like an immediate freeze.
  function automatic logic [1:0] norm_mode(input logic [1:0] m);
    return (m == 2'd3) ? MODE_IMMEDIATE : m;
  endfunction

endpackage

// File: rtl/spy_dpram.sv
// Simple dual-port RAM: one write port, one registered read port returning old data on collision.
module spy_dpram
  import spy_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int WIDTH      = 33
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  write_enable,
  input  logic [ADDR_WIDTH-1:0] write_addr,
  input  logic [WIDTH-1:0]      write_data,
  input  logic                  read_enable,
  input  logic [ADDR_WIDTH-1:0] read_addr,
  output logic [WIDTH-1:0]      read_data
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  // Array has no reset so it maps onto block RAM; only the output register clears.
  always_ff @(posedge clock) begin
    if (write_enable) mem[write_addr] <= write_data;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)           read_data <= '0;
    else if (read_enable) read_data <= mem[read_addr];
  end

endmodule

// File: rtl/spy_recorder.sv
// Circular spy memory with event list and a record/armed/frozen trigger FSM.
module spy_recorder
  import spy_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_WIDTH  = 7,
  parameter int META_WIDTH = 4,
  parameter int POST_WIDTH = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [DATA_WIDTH:0]   data_in,
  input  logic                  write_enable,
  input  logic [1:0]            mode,
  input  logic [POST_WIDTH-1:0] post_count,
  input  logic                  freeze_req,
  input  logic                  release_req,
  input  logic                  read_enable,
  input  logic [MEM_WIDTH-1:0]  read_addr,
  output logic [DATA_WIDTH:0]   data_out,
  input  logic                  meta_read_enable,
  input  logic [META_WIDTH-1:0] meta_read_addr,
  output logic [MEM_WIDTH:0]    meta_read_data,
  output logic [MEM_WIDTH-1:0]  write_ptr,
  output logic [META_WIDTH-1:0] meta_write_ptr,
  output logic                  wrapped,
  output logic                  frozen
);

  localparam int META_DEPTH = 2**META_WIDTH;

  state_t                state, state_n;
  logic [1:0]            mode_q, mode_n;
  logic [POST_WIDTH-1:0] cnt, cnt_n;
  logic                  mem_we;
  logic                  meta_we;
  logic                  clr_wrap;
  logic                  eoe;
  logic [MEM_WIDTH-1:0]  next_wptr;
  logic [META_DEPTH-1:0] meta_valid;
  logic                  meta_valid_rd;
  logic [MEM_WIDTH-1:0]  meta_addr_rd;

  assign eoe       = data_in[DATA_WIDTH];
  assign next_wptr = write_ptr + MEM_WIDTH'(1);
  assign meta_we   = mem_we & eoe;

  always_comb begin
    state_n  = state;
    mode_n   = mode_q;
    cnt_n    = cnt;
    mem_we   = 1'b0;
    clr_wrap = 1'b0;
    unique case (state)
      ST_RECORD: begin
        if (freeze_req) begin
          mode_n = norm_mode(mode);
          unique case (norm_mode(mode))
            MODE_POST_COUNT: begin
              mem_we  = write_enable;
              cnt_n   = post_count;
              state_n = (post_count == '0) ? ST_FROZEN : ST_ARMED;
            end
            MODE_EVENT_END: begin
              mem_we  = write_enable;
              state_n = (write_enable && eoe) ? ST_FROZEN : ST_ARMED;
            end
            default: state_n = ST_FROZEN;
          endcase
        end else begin
          mem_we = write_enable;
        end
      end
      ST_ARMED: begin
        mem_we = write_enable;
        if (mode_q == MODE_POST_COUNT) begin
          if (write_enable) begin
            cnt_n = cnt - POST_WIDTH'(1);
            if (cnt == POST_WIDTH'(1)) state_n = ST_FROZEN;
          end
        end else if (mode_q == MODE_EVENT_END) begin
          if (write_enable && eoe) state_n = ST_FROZEN;
        end else begin
          state_n = ST_FROZEN;
        end
      end
      ST_FROZEN: begin
        if (release_req) begin
          state_n  = ST_RECORD;
          clr_wrap = 1'b1;
        end
      end
      default: state_n = ST_RECORD;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state  <= ST_RECORD;
      mode_q <= MODE_IMMEDIATE;
      cnt    <= '0;
      frozen <= 1'b0;
    end else begin
      state  <= state_n;
      mode_q <= mode_n;
      cnt    <= cnt_n;
      frozen <= (state_n == ST_FROZEN);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      write_ptr      <= '0;
      meta_write_ptr <= '0;
      wrapped        <= 1'b0;
      meta_valid     <= '0;
    end else begin
      if (mem_we) begin
        write_ptr <= next_wptr;
        if (&write_ptr) wrapped <= 1'b1;
      end
      if (clr_wrap) wrapped <= 1'b0;
      if (meta_we) begin
        meta_write_ptr             <= meta_write_ptr + META_WIDTH'(1);
        meta_valid[meta_write_ptr] <= 1'b1;
      end
    end
  end

  // Valid bits live in flops so reset can clear them; addresses live in RAM.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                meta_valid_rd <= 1'b0;
    else if (meta_read_enable) meta_valid_rd <= meta_valid[meta_read_addr];
  end

  assign meta_read_data = {meta_valid_rd, meta_addr_rd};

  spy_dpram #(
    .ADDR_WIDTH (MEM_WIDTH),
    .WIDTH      (DATA_WIDTH + 1)
  ) u_spy_mem (
    .clock        (clock),
    .reset        (reset),
    .write_enable (mem_we),
    .write_addr   (write_ptr),
    .write_data   (data_in),
    .read_enable  (read_enable),
    .read_addr    (read_addr),
    .read_data    (data_out)
  );

  spy_dpram #(
    .ADDR_WIDTH (META_WIDTH),
    .WIDTH      (MEM_WIDTH)
  ) u_event_list (
    .clock        (clock),
    .reset        (reset),
    .write_enable (meta_we),
    .write_addr   (meta_write_ptr),
    .write_data   (next_wptr),
    .read_enable  (meta_read_enable),
    .read_addr    (meta_read_addr),
    .read_data    (meta_addr_rd)
  );

endmodule

// File: tb/tb_spy_recorder.sv
// Scoreboard bench for spy_recorder: reads queue expected data, a monitor checks returned data.
module tb_spy_recorder;

  logic        clock;
  logic        reset;
  logic [32:0] data_in;
  logic        write_enable;
  logic [1:0]  mode;
  logic [7:0]  post_count;
  logic        freeze_req;
  logic        release_req;
  logic        read_enable;
  logic [6:0]  read_addr;
  logic [32:0] data_out;
  logic        meta_read_enable;
  logic [3:0]  meta_read_addr;
  logic [7:0]  meta_read_data;
  logic [6:0]  write_ptr;
  logic [3:0]  meta_write_ptr;
  logic        wrapped;
  logic        frozen;

  spy_recorder #(
    .DATA_WIDTH (32),
    .MEM_WIDTH  (7),
    .META_WIDTH (4),
    .POST_WIDTH (8)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .data_in          (data_in),
    .write_enable     (write_enable),
    .mode             (mode),
    .post_count       (post_count),
    .freeze_req       (freeze_req),
    .release_req      (release_req),
    .read_enable      (read_enable),
    .read_addr        (read_addr),
    .data_out         (data_out),
    .meta_read_enable (meta_read_enable),
    .meta_read_addr   (meta_read_addr),
    .meta_read_data   (meta_read_data),
    .write_ptr        (write_ptr),
    .meta_write_ptr   (meta_write_ptr),
    .wrapped          (wrapped),
    .frozen           (frozen)
  );

  typedef struct {
    string       name;
    logic [63:0] exp;
    logic [63:0] mask;
  } exp_t;

  exp_t rd_q[$];
  exp_t meta_q[$];
  int   checks = 0;
  int   errors = 0;
  logic rd_vld = 1'b0;
  logic meta_vld = 1'b0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) begin
    rd_vld   <= read_enable;
    meta_vld <= meta_read_enable;
  end

  // Monitor: each read presented by the DUT is matched against the oldest queued expectation.
  always @(negedge clock) begin
    exp_t e;
    if (rd_vld) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rd_unexpected: got %0h, no expectation queued", data_out);
      end else begin
        e = rd_q.pop_front();
        if ((64'(data_out) & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h", e.name, data_out, e.exp);
        end
      end
    end
    if (meta_vld) begin
      checks++;
      if (meta_q.size() == 0) begin
        errors++;
        $display("FAIL meta_unexpected: got %0h, no expectation queued", meta_read_data);
      end else begin
        e = meta_q.pop_front();
        if ((64'(meta_read_data) & e.mask) !== (e.exp & e.mask)) begin
          errors++;
          $display("FAIL %s: got %0h expected %0h (mask %0h)", e.name, meta_read_data, e.exp, e.mask);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
    write_enable     = 1'b0;
    freeze_req       = 1'b0;
    release_req      = 1'b0;
    read_enable      = 1'b0;
    meta_read_enable = 1'b0;
  endtask

  task automatic wr(input logic eoe, input logic [31:0] d);
    data_in      = {eoe, d};
    write_enable = 1'b1;
    step();
  endtask

  task automatic push_rd(input string name, input int a, input logic [32:0] exp);
    exp_t e;
    e.name = name;
    e.exp  = 64'(exp);
    e.mask = {64{1'b1}};
    read_enable = 1'b1;
    read_addr   = 7'(a);
    rd_q.push_back(e);
  endtask

  task automatic rd(input string name, input int a, input logic [32:0] exp);
    push_rd(name, a, exp);
    step();
  endtask

  task automatic mrd(input string name, input int a, input logic [7:0] exp, input logic [7:0] mask);
    exp_t e;
    e.name = name;
    e.exp  = 64'(exp);
    e.mask = 64'(mask);
    meta_read_enable = 1'b1;
    meta_read_addr   = 4'(a);
    meta_q.push_back(e);
    step();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;
    step();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b0;
    data_in          = '0;
    write_enable     = 1'b0;
    mode             = 2'd0;
    post_count       = 8'd0;
    freeze_req       = 1'b0;
    release_req      = 1'b0;
    read_enable      = 1'b0;
    read_addr        = '0;
    meta_read_enable = 1'b0;
    meta_read_addr   = '0;

    do_reset();
    chk("rst_write_ptr", 64'(write_ptr), 64'd0);
    chk("rst_meta_write_ptr", 64'(meta_write_ptr), 64'd0);
    chk("rst_wrapped", 64'(wrapped), 64'd0);
    chk("rst_frozen", 64'(frozen), 64'd0);
    chk("rst_data_out", 64'(data_out), 64'd0);
    chk("rst_meta_read_data", 64'(meta_read_data), 64'd0);

    // Immediate freeze: the word presented with the trigger is dropped.
    for (int i = 0; i < 11; i++) wr(1'b0, 32'h1000 + i);
    do_reset();
    for (int i = 0; i < 10; i++) wr(1'b0, 32'h2000 + i);
    mode = 2'd0; freeze_req = 1'b1; data_in = {1'b0, 32'h200A}; write_enable = 1'b1;
    step();
    step();
    chk("m0_frozen", 64'(frozen), 64'd1);
    chk("m0_write_ptr", 64'(write_ptr), 64'd10);
    rd("m0_addr10_unwritten", 10, {1'b0, 32'h100A});
    rd("m0_addr9", 9, {1'b0, 32'h2009});
    wr(1'b0, 32'h2FFF);
    chk("m0_frozen_ptr_hold", 64'(write_ptr), 64'd10);
    freeze_req = 1'b1; release_req = 1'b1;
    step();
    step();
    chk("m0_release_with_freeze", 64'(frozen), 64'd0);

    // Post-count freeze: trigger word stored but not counted; re-trigger while armed ignored.
    do_reset();
    for (int i = 0; i < 20; i++) wr(1'b0, 32'h3000 + i);
    mode = 2'd1; post_count = 8'd5; freeze_req = 1'b1;
    wr(1'b0, 32'h3014);
    wr(1'b0, 32'h3015);
    mode = 2'd0; freeze_req = 1'b1;
    wr(1'b0, 32'h3016);
    wr(1'b0, 32'h3017);
    wr(1'b0, 32'h3018);
    step();
    chk("m1_not_yet_frozen", 64'(frozen), 64'd0);
    wr(1'b0, 32'h3019);
    wr(1'b0, 32'h301A);
    step();
    chk("m1_frozen", 64'(frozen), 64'd1);
    chk("m1_write_ptr", 64'(write_ptr), 64'd26);
    rd("m1_addr25", 25, {1'b0, 32'h3019});
    rd("m1_addr20", 20, {1'b0, 32'h3014});
    release_req = 1'b1;
    step();
    mode = 2'd1; post_count = 8'd0; freeze_req = 1'b1;
    wr(1'b0, 32'h3100);
    step();
    chk("m1_zero_frozen", 64'(frozen), 64'd1);
    chk("m1_zero_write_ptr", 64'(write_ptr), 64'd27);
    rd("m1_zero_addr26", 26, {1'b0, 32'h3100});

    // Event-end freeze: trigger mid-event, freeze on the following EOE.
    do_reset();
    wr(1'b0, 32'h4000);
    wr(1'b1, 32'h4001);
    wr(1'b0, 32'h4002);
    mode = 2'd2; freeze_req = 1'b1;
    wr(1'b0, 32'h4003);
    mode = 2'd0;
    wr(1'b0, 32'h4004);
    wr(1'b0, 32'h4005);
    wr(1'b1, 32'h4006);
    wr(1'b0, 32'h4007);
    step();
    chk("m2_frozen", 64'(frozen), 64'd1);
    chk("m2_write_ptr", 64'(write_ptr), 64'd7);
    chk("m2_meta_write_ptr", 64'(meta_write_ptr), 64'd2);
    mrd("m2_meta1", 1, 8'h87, 8'hFF);
    mrd("m2_meta0", 0, 8'h82, 8'hFF);
    mrd("m2_meta2_invalid", 2, 8'h00, 8'h80);
    release_req = 1'b1;
    step();
    mode = 2'd2; freeze_req = 1'b1;
    wr(1'b1, 32'h4107);
    step();
    chk("m2_same_cycle_frozen", 64'(frozen), 64'd1);
    chk("m2_same_cycle_write_ptr", 64'(write_ptr), 64'd8);
    chk("m2_same_cycle_meta_ptr", 64'(meta_write_ptr), 64'd3);
    mrd("m2_same_cycle_meta2", 2, 8'h88, 8'hFF);

    // Wrap: 200 words into 128 locations, with a read colliding with a write.
    do_reset();
    for (int i = 0; i < 200; i++) begin
      if (i == 127) chk("wrap_before_last", 64'(wrapped), 64'd0);
      if (i == 128) chk("wrap_after_last", 64'(wrapped), 64'd1);
      if (i == 130) push_rd("rd_during_write_old", 2, {1'b0, 32'h5002});
      wr(1'b0, 32'h5000 + i);
    end
    chk("wrap_write_ptr", 64'(write_ptr), 64'd72);
    chk("wrap_flag", 64'(wrapped), 64'd1);
    rd("wrap_addr0", 0, {1'b0, 32'h5080});
    rd("wrap_addr71", 71, {1'b0, 32'h50C7});
    rd("wrap_addr72", 72, {1'b0, 32'h5048});
    rd("wrap_addr2", 2, {1'b0, 32'h5082});
    step();
    step();
    chk("rd_hold", 64'(data_out), 64'(33'h0_0000_5082));
    mode = 2'd0; freeze_req = 1'b1;
    step();
    step();
    chk("wrap_kept_frozen", 64'(wrapped), 64'd1);
    release_req = 1'b1;
    step();
    step();
    chk("wrap_cleared_release", 64'(wrapped), 64'd0);
    chk("wrap_ptr_kept_release", 64'(write_ptr), 64'd72);

    // Event list overwrite: 18 EOE words into 16 entries.
    do_reset();
    for (int i = 0; i < 18; i++) wr(1'b1, 32'h6000 + i);
    chk("meta_wrap_ptr", 64'(meta_write_ptr), 64'd2);
    chk("meta_wrap_write_ptr", 64'(write_ptr), 64'd18);
    mrd("meta_entry0", 0, 8'h91, 8'hFF);
    mrd("meta_entry1", 1, 8'h92, 8'hFF);
    mrd("meta_entry15", 15, 8'h90, 8'hFF);
    mrd("meta_entry2", 2, 8'h83, 8'hFF);
    step();
    step();
    chk("meta_hold", 64'(meta_read_data), 64'h83);

    // Reset while armed abandons the freeze completely.
    do_reset();
    wr(1'b1, 32'h7000);
    wr(1'b0, 32'h7001);
    wr(1'b0, 32'h7002);
    mode = 2'd1; post_count = 8'd10; freeze_req = 1'b1;
    wr(1'b0, 32'h7003);
    wr(1'b0, 32'h7004);
    wr(1'b0, 32'h7005);
    rd("armed_rd0", 0, {1'b1, 32'h7000});
    mrd("armed_meta0", 0, 8'h81, 8'hFF);
    step();
    reset = 1'b0;
    #2;
    chk("armrst_write_ptr", 64'(write_ptr), 64'd0);
    chk("armrst_meta_write_ptr", 64'(meta_write_ptr), 64'd0);
    chk("armrst_wrapped", 64'(wrapped), 64'd0);
    chk("armrst_frozen", 64'(frozen), 64'd0);
    chk("armrst_data_out", 64'(data_out), 64'd0);
    chk("armrst_meta_read_data", 64'(meta_read_data), 64'd0);
    @(negedge clock);
    reset = 1'b1;
    step();
    mrd("armrst_meta0_cleared", 0, 8'h00, 8'h80);
    mode = 2'd1; post_count = 8'd2; freeze_req = 1'b1;
    wr(1'b0, 32'h7100);
    wr(1'b0, 32'h7101);
    wr(1'b0, 32'h7102);
    wr(1'b0, 32'h7103);
    step();
    chk("armrst_refreeze_frozen", 64'(frozen), 64'd1);
    chk("armrst_refreeze_write_ptr", 64'(write_ptr), 64'd3);

    step();
    step();
    chk("scoreboard_drained", 64'(rd_q.size() + meta_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
